// File: rtl/bcd2dual_pkg.sv
// Shared types for the BCD-to-binary converter: FSM states and a digit check.
package bcd2dual_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic digit_ok(input logic [3:0] digit);
    return digit <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd2dual_digit_adjust.sv
// One BCD digit of the reverse double-dabble correction step.
module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= 4'd8) adjusted = digit - 4'd3;
  end

endmodule

// File: rtl/bcd2dual.sv
// Iterative BCD-to-binary converter (reverse double-dabble), start/finish handshake.
module bcd2dual
  import bcd2dual_pkg::*;
#(
  parameter int unsigned bcdwidth  = 16,
  parameter int unsigned dualwidth = 14
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [bcdwidth-1:0]  bcd,
  output logic                 busy,
  output logic                 finish,
  output logic                 error,
  output logic [dualwidth-1:0] dual
);

  localparam int unsigned bcddigit = bcdwidth / 4;
  localparam int unsigned cw       = $clog2(dualwidth + 1);
  localparam logic [cw-1:0] last   = cw'(dualwidth - 1);

  state_t                state, state_next;
  logic [bcdwidth-1:0]   work;
  logic [bcdwidth-1:0]   work_shift;
  logic [bcdwidth-1:0]   work_adj;
  logic [dualwidth-1:0]  acc;
  logic [cw-1:0]         count;
  logic                  invalid;
  logic                  bad;

  always_comb begin
    bad = 1'b0;
    for (int unsigned i = 0; i < bcddigit; i++) begin
      if (!digit_ok(bcd[4*i +: 4])) bad = 1'b1;
    end
  end

  // Shift first, then correct every digit that received a bit from above.
  assign work_shift = work >> 1;

  genvar g;
  for (g = 0; g < bcddigit; g++) begin : g_digit
    bcd_digit_adjust u_adjust (
      .digit    (work_shift[4*g +: 4]),
      .adjusted (work_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = SHIFT;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        SHIFT:   if (count == last) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      work    <= '0;
      acc     <= '0;
      count   <= '0;
      invalid <= 1'b0;
      busy    <= 1'b0;
      finish  <= 1'b0;
      error   <= 1'b0;
      dual    <= '0;
    end else begin
      finish <= 1'b0;
      if (start) begin
        work    <= bcd;
        acc     <= '0;
        count   <= '0;
        invalid <= bad;
        busy    <= 1'b1;
      end else begin
        case (state)
          SHIFT: begin
            acc   <= {work[0], acc[dualwidth-1:1]};
            work  <= work_adj;
            count <= count + 1'b1;
          end
          DONE: begin
            finish <= 1'b1;
            busy   <= 1'b0;
            error  <= invalid;
            dual   <= invalid ? '0 : acc;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd2dual.sv
// Directed-vector bench for bcd2dual with hand-computed expected results.
module tb_bcd2dual;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] bcd;
  logic        busy;
  logic        finish;
  logic        error;
  logic [13:0] dual;

  int checks = 0;
  int passes = 0;

  bcd2dual #(.bcdwidth(16), .dualwidth(14)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .bcd     (bcd),
    .busy    (busy),
    .finish  (finish),
    .error   (error),
    .dual    (dual)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passes++;
  endtask

  // For legal operands the work register must be drained when the result appears.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && finish === 1'b1 && error === 1'b0)
      check("residual", 32'(dut.work), 32'h0);
  end

  task automatic convert(input string tag, input logic [15:0] v,
                         input logic [13:0] exp_d, input logic exp_e);
    int n;
    @(negedge clock);
    bcd   = v;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    bcd   = ~v;
    n = 0;
    while (finish !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd15);
    check({tag, "_dual"}, 32'(dual), 32'(exp_d));
    check({tag, "_error"}, 32'(error), 32'(exp_e));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    @(negedge clock);
    check({tag, "_finish_pulse"}, 32'(finish), 32'd0);
  endtask

  initial begin
    int n;
    int nfin;
    int lat;

    reset_n = 1'b0;
    start   = 1'b0;
    bcd     = 16'h9999;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_finish", 32'(finish), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_dual", 32'(dual), 32'd0);
    nfin = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (finish === 1'b1 || busy === 1'b1) nfin++;
    end
    check("reset_no_start", 32'(nfin), 32'd0);

    convert("zero", 16'h0000, 14'd0, 1'b0);
    convert("max", 16'h9999, 14'd9999, 1'b0);
    convert("mid", 16'h1234, 14'h04D2, 1'b0);

    nfin = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (finish === 1'b1) nfin++;
    end
    check("mid_hold_dual", 32'(dual), 32'h04D2);
    check("mid_hold_nofinish", 32'(nfin), 32'd0);

    convert("invalid", 16'h12A4, 14'd0, 1'b1);
    convert("after_invalid", 16'h0042, 14'd42, 1'b0);

    // Restart: second start six edges after the first.
    @(negedge clock);
    bcd   = 16'h0500;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    nfin  = 0;
    repeat (5) begin
      @(negedge clock);
      if (finish === 1'b1) nfin++;
    end
    bcd   = 16'h0007;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat   = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (finish === 1'b1) begin
        nfin++;
        if (lat < 0) lat = i;
      end
    end
    check("restart_finish_count", 32'(nfin), 32'd1);
    check("restart_latency", 32'(lat), 32'd15);
    check("restart_dual", 32'(dual), 32'd7);

    // Reset at the eighth edge of a conversion.
    @(negedge clock);
    bcd   = 16'h9999;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_finish", 32'(finish), 32'd0);
    check("midreset_error", 32'(error), 32'd0);
    check("midreset_dual", 32'(dual), 32'd0);
    n = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (finish === 1'b1) n++;
    end
    check("midreset_no_finish", 32'(n), 32'd0);

    convert("after_reset", 16'h0315, 14'd315, 1'b0);
    convert("mixed", 16'h8080, 14'd8080, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
